// File: rtl/jk_cnt_pkg.sv
// jk_cnt_pkg
// Shared definitions for the JK-cell modulo counter:
//   - jk_cmd_e : JK command encodings, packed as {J,K}
//   - JK_DEF_WIDTH / JK_DEF_MODULUS : default counter geometry (BCD digit)
//   - jk_load_cmd() : excitation that forces a cell to a given bit value
package jk_cnt_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

  localparam int JK_DEF_WIDTH   = 4;
  localparam int JK_DEF_MODULUS = 10;

  // J=b, K=~b : the cell takes the value b on the next active edge.
  function automatic jk_cmd_e jk_load_cmd(input logic b);
    return b ? JK_SET : JK_CLR;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell
// Single JK flip-flop, falling-edge clocked, asynchronous active-low reset.
// Ports:
//   clk   : clock, state changes on the falling edge
//   reset : asynchronous, active-low; forces q=0 / qb=1
//   j, k  : JK excitation (00 hold, 01 clear, 10 set, 11 toggle)
//   q, qb : true and complementary outputs, qb is always ~q
module jk_cell
  import jk_cnt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_reg;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= 1'b0;
    end else begin
      case (jk_cmd_e'({j, k}))
        JK_HOLD: q_reg <= q_reg;
        JK_CLR:  q_reg <= 1'b0;
        JK_SET:  q_reg <= 1'b1;
        JK_TGL:  q_reg <= ~q_reg;
      endcase
    end
  end

  assign q  = q_reg;
  assign qb = ~q_reg;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter
// Synchronous modulo-MODULUS counter built from WIDTH jk_cell instances.
// A purely combinational excitation block computes each cell's J/K pair;
// every flip-flop lives inside the cells.
// Parameters:
//   WIDTH   : number of JK cells / count bits
//   MODULUS : count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
// Ports:
//   clk   : clock, all state changes on the falling edge
//   reset : asynchronous, active-low clear
//   en    : count enable
//   load  : parallel load strobe (wins over en)
//   din   : parallel load value, values >= MODULUS load as 0
//   dir   : 1=up, 0=down (only with JK_CNT_UPDOWN_EN defined)
//   q/qb  : count and its complement (from the cells' qb outputs)
//   tc    : terminal count, combinational, for cascading
// Optional feature macro: JK_CNT_UPDOWN_EN (adds dir and down counting).
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = JK_DEF_WIDTH,
  parameter int MODULUS = JK_DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef JK_CNT_UPDOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS out of range for WIDTH");
  end

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] din_c;
  logic             at_top;
  logic             out_of_range;
  logic [WIDTH:0]   up_carry;

  // Out-of-range loads clamp to zero so no illegal count is ever entered.
  assign din_c        = ({1'b0, din} < MOD_EXT) ? din : '0;
  assign at_top       = (q == TOP);
  assign out_of_range = ({1'b0, q} >= MOD_EXT);

  // up_carry[i] = &q[i-1:0]; bit 0 always toggles when counting up.
  assign up_carry[0] = 1'b1;

`ifdef JK_CNT_UPDOWN_EN
  logic           at_zero;
  logic [WIDTH:0] dn_borrow;

  assign at_zero      = (q == '0);
  assign dn_borrow[0] = 1'b1;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_cmd_e cmd;

    assign up_carry[gi+1] = up_carry[gi] & q[gi];
`ifdef JK_CNT_UPDOWN_EN
    assign dn_borrow[gi+1] = dn_borrow[gi] & ~q[gi];
`endif

    always_comb begin
      cmd = JK_HOLD;
      if (load) begin
        cmd = jk_load_cmd(din_c[gi]);
      end else if (en) begin
`ifdef JK_CNT_UPDOWN_EN
        if (!dir) begin
          // Down: 0 reloads MODULUS-1; an illegal value recovers to 0.
          if (out_of_range)
            cmd = JK_CLR;
          else if (at_zero)
            cmd = jk_load_cmd(TOP[gi]);
          else
            cmd = dn_borrow[gi] ? JK_TGL : JK_HOLD;
        end else
`endif
        begin
          // Up: the top value and any illegal value both wrap to 0.
          if (at_top || out_of_range)
            cmd = JK_CLR;
          else
            cmd = up_carry[gi] ? JK_TGL : JK_HOLD;
        end
      end
    end

    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (cmd[1]),
      .k     (cmd[0]),
      .q     (q[gi]),
      .qb    (qb[gi])
    );
  end

  // Gated with reset so tc is low while held in reset (q=0 would otherwise
  // look like a down-count terminal).
`ifdef JK_CNT_UPDOWN_EN
  assign tc = reset & en & (dir ? at_top : at_zero);
`else
  assign tc = reset & en & at_top;
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter
// Randomised and directed checks of jk_mod_counter against an arithmetic
// model of the modulo counter, plus a two-digit cascade.
// Build with +define+JK_CNT_UPDOWN_EN to also exercise down counting.
module tb_jk_mod_counter;
  import jk_cnt_pkg::*;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] din;
`ifdef JK_CNT_UPDOWN_EN
  logic         dir;
`endif
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;

  // cascade pair
  logic         c_reset;
  logic         c_en;
  logic         c_load;
  logic [W-1:0] c_din;
  logic [W-1:0] u_q, u_qb, t_q, t_qb;
  logic         u_tc, t_tc;

  int checks   = 0;
  int failures = 0;
  int model_q  = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (load),
    .din   (din),
`ifdef JK_CNT_UPDOWN_EN
    .dir   (dir),
`endif
    .q     (q),
    .qb    (qb),
    .tc    (tc)
  );

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) u_units (
    .clk   (clk),
    .reset (c_reset),
    .en    (c_en),
    .load  (c_load),
    .din   (c_din),
`ifdef JK_CNT_UPDOWN_EN
    .dir   (1'b1),
`endif
    .q     (u_q),
    .qb    (u_qb),
    .tc    (u_tc)
  );

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) u_tens (
    .clk   (clk),
    .reset (c_reset),
    .en    (u_tc),
    .load  (c_load),
    .din   (c_din),
`ifdef JK_CNT_UPDOWN_EN
    .dir   (1'b1),
`endif
    .q     (t_q),
    .qb    (t_qb),
    .tc    (t_tc)
  );

  function automatic bit cur_up();
`ifdef JK_CNT_UPDOWN_EN
    return dir;
`else
    return 1'b1;
`endif
  endfunction

  // Counter rules in plain integer arithmetic.
  function automatic int next_q(int m, bit l, bit e, int d, bit up);
    if (l) return (d < M) ? d : 0;
    if (!e) return m;
    if (m >= M) return 0;
    if (up) return (m == M - 1) ? 0 : m + 1;
    return (m == 0) ? M - 1 : m - 1;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on the same falling edges as the DUT.
  always @(negedge clk or negedge reset) begin
    if (!reset) model_q = 0;
    else        model_q = next_q(model_q, load, en, int'(din), cur_up());
  end

  // Compare process: mid-cycle, after inputs and state have settled.
  always @(posedge clk) begin
    int exp_tc;
    exp_tc = (reset && en && (cur_up() ? (model_q == M - 1) : (model_q == 0))) ? 1 : 0;
    check("model_q",  int'(q),  model_q);
    check("model_qb", int'(qb), (~model_q) & ((1 << W) - 1));
    check("model_tc", int'(tc), exp_tc);
  end

  task automatic drive(bit l, bit e, int d, bit dr);
    @(negedge clk);
    #2;
    load = l;
    en   = e;
    din  = W'(d);
`ifdef JK_CNT_UPDOWN_EN
    dir  = dr;
`endif
    $display("txn t=%0t load=%0b en=%0b din=%0d dir=%0b q=%0d", $time, l, e, d, dr, q);
  endtask

  task automatic pin(string name, int exp_q, int exp_tc);
    @(posedge clk);
    #1;
    check({name, "_q"},  int'(q),  exp_q);
    check({name, "_qb"}, int'(qb), (~exp_q) & ((1 << W) - 1));
    check({name, "_tc"}, int'(tc), exp_tc);
  endtask

  initial begin
    int prev_u, prev_t;
    reset   = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    din     = '0;
`ifdef JK_CNT_UPDOWN_EN
    dir     = 1'b1;
`endif
    c_reset = 1'b0;
    c_en    = 1'b1;
    c_load  = 1'b0;
    c_din   = '0;

    // reset state, edges ignored while held
    repeat (3) @(negedge clk);
    #1;
    check("rst_q", int'(q), 0);
    check("rst_qb", int'(qb), 15);
    check("rst_tc", int'(tc), 0);
    #1;
    reset = 1'b1;

    // load, clamp, load beats enable
    drive(1, 0, 5, 1);
    drive(0, 0, 0, 1);
    pin("load5", 5, 0);
    drive(1, 0, 12, 1);
    drive(0, 0, 0, 1);
    pin("clamp12", 0, 0);
    drive(1, 1, 3, 1);
    drive(0, 0, 0, 1);
    pin("load_wins", 3, 0);

    // hold at 4 for five edges
    drive(1, 0, 4, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      pin("hold", 4, 0);
    end

    // wrap: 0 -> 1..9 -> 0, tc only at 9
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 1);
    pin("wrap0", 0, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 0, 1);
      pin("wrap", k % 10, (k % 10 == 9) ? 1 : 0);
    end

`ifdef JK_CNT_UPDOWN_EN
    // down: 1 -> 0 (tc) -> 9 -> 8, then dir toggles with en=0
    drive(1, 0, 1, 0);
    drive(0, 1, 0, 0);
    pin("down1", 1, 0);
    drive(0, 1, 0, 0);
    pin("down0", 0, 1);
    drive(0, 1, 0, 0);
    pin("down9", 9, 0);
    drive(0, 0, 0, 1);
    pin("down8", 8, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    pin("dir_noen", 8, 0);
`endif

    // asynchronous reset mid-cycle from q=7
    drive(1, 0, 7, 1);
    drive(0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("pre_rst_q", int'(q), 7);
    #2;
    reset = 1'b0;
    load  = 1'b1;
    din   = 4'd5;
    en    = 1'b1;
    #1;
    check("async_q", int'(q), 0);
    check("async_qb", int'(qb), 15);
    check("async_tc", int'(tc), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_q", int'(q), 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    load  = 1'b0;
    en    = 1'b0;

    // randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 8) == 0, ($urandom % 4) != 0, int'($urandom % 16), $urandom % 2);
    end
    drive(0, 0, 0, 1);

    // cascade: units.tc enables tens, 25 edges from 0
    @(negedge clk);
    #2;
    c_reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      prev_u = int'(u_q);
      prev_t = int'(t_q);
      @(negedge clk);
      #1;
      check("units_step", int'(u_q), (prev_u + 1) % 10);
      if (int'(t_q) != prev_t) check("tens_on_wrap", prev_u, 9);
    end
    check("cascade_units", int'(u_q), 5);
    check("cascade_tens", int'(t_q), 2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
